rho_rotate: RTL and testbench

- Keccak rho stage, directly downstream of column-parity/theta. Consumes the theta-applied state from a slice-organised memory: 64 words × 25 bits, word z = slice z, bit i = 5*y + x.
- Writes the rho-rotated state into a separate output slice memory.
- Same start/ready handshake as the other encoder stages. Implemented as controller plus datapath.

---
 rtl/rho_rotate_pkg.sv | 35 +++
 rtl/rho_rotate_controller.sv | 57 +++++
 rtl/rho_rotate_datapath.sv | 61 ++++++
 rtl/rho_rotate.sv | 48 ++++
 tb/tb_rho_rotate.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rho_rotate_pkg.sv
// Shared Keccak constants for the rho stage: slice geometry, rotation table
// and the controller state encoding.
package rho_rotate_pkg;

    localparam int SLICES = 64;
    localparam int LANES  = 25;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_e;

    // Rotation offset for lane bit i = 5*y + x.
    function automatic logic [ADDR_W-1:0] rho_off(input logic [4:0] i);
        logic [ADDR_W-1:0] r;
        case (i)
            5'd0:  r = 6'd0;   5'd1:  r = 6'd1;   5'd2:  r = 6'd62;
            5'd3:  r = 6'd28;  5'd4:  r = 6'd27;  5'd5:  r = 6'd36;
            5'd6:  r = 6'd44;  5'd7:  r = 6'd6;   5'd8:  r = 6'd55;
            5'd9:  r = 6'd20;  5'd10: r = 6'd3;   5'd11: r = 6'd10;
            5'd12: r = 6'd43;  5'd13: r = 6'd25;  5'd14: r = 6'd39;
            5'd15: r = 6'd41;  5'd16: r = 6'd45;  5'd17: r = 6'd15;
            5'd18: r = 6'd21;  5'd19: r = 6'd8;   5'd20: r = 6'd18;
            5'd21: r = 6'd2;   5'd22: r = 6'd61;  5'd23: r = 6'd56;
            5'd24: r = 6'd14;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rho_rotate_controller.sv
// Rho stage sequencer: start/ready handshake and per-slice collect/write phases.
module rho_rotate_controller
    import rho_rotate_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic co_c25_i,
    input  logic co_c64_i,
    output logic cnt_init_o,
    output logic collect_o,
    output logic write_o,
    output logic busy_o,
    output logic ready_o
);

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_init_o = 1'b0;
        collect_o  = 1'b0;
        write_o    = 1'b0;
        busy_o     = 1'b0;
        ready_o    = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_START;
            // Launch happens on the falling edge of start.
            S_START: begin
                cnt_init_o = 1'b1;
                busy_o     = 1'b1;
                if (!start_i) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                collect_o = 1'b1;
                busy_o    = 1'b1;
                if (co_c25_i) state_d = S_WRITE;
            end
            S_WRITE: begin
                write_o = 1'b1;
                busy_o  = 1'b1;
                state_d = co_c64_i ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                ready_o = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/rho_rotate_datapath.sv
// Rho datapath: slice/lane counters, rotated read address and slice assembly.
module rho_rotate_datapath
    import rho_rotate_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_init_i,
    input  logic              collect_i,
    input  logic              write_i,
    input  logic [LANES-1:0]  rd_data_i,
    output logic              co_c25_o,
    output logic              co_c64_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [LANES-1:0]  wr_data_o
);

    logic [ADDR_W-1:0] z_q, z_d;
    logic [4:0]        i_q, i_d;
    logic [LANES-1:0]  acc_q, acc_d;

    assign co_c25_o = (i_q == 5'd24);
    assign co_c64_o = (z_q == 6'd63);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q   <= '0;
            i_q   <= '0;
            acc_q <= '0;
        end else begin
            z_q   <= z_d;
            i_q   <= i_d;
            acc_q <= acc_d;
        end
    end

    always_comb begin
        z_d   = z_q;
        i_d   = i_q;
        acc_d = acc_q;
        if (cnt_init_i) begin
            z_d = '0;
            i_d = '0;
        end
        // One lane bit per cycle; acc needs no clear since all 25 bits are refreshed.
        if (collect_i) begin
            acc_d[i_q] = rd_data_i[i_q];
            i_d        = co_c25_o ? 5'd0 : i_q + 5'd1;
        end
        if (write_i) begin
            i_d = '0;
            z_d = z_q + 6'd1;
        end
    end

    // Mod-64 wrap falls out of the 6-bit subtraction.
    assign rd_addr_o = collect_i ? (z_q - rho_off(i_q)) : '0;
    assign wr_addr_o = write_i ? z_q : '0;
    assign wr_data_o = write_i ? acc_q : '0;

endmodule

// File: rtl/rho_rotate.sv
// Keccak rho stage top: reads theta-applied slices, writes lane-rotated slices.
module rho_rotate
    import rho_rotate_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [LANES-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LANES-1:0]  wr_data,
    output logic              busy,
    output logic              ready
);

    logic cnt_init, collect, write, co_c25, co_c64;

    rho_rotate_controller u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .co_c25_i   (co_c25),
        .co_c64_i   (co_c64),
        .cnt_init_o (cnt_init),
        .collect_o  (collect),
        .write_o    (write),
        .busy_o     (busy),
        .ready_o    (ready)
    );

    rho_rotate_datapath u_dp (
        .clk        (clk),
        .rst        (rst),
        .cnt_init_i (cnt_init),
        .collect_i  (collect),
        .write_i    (write),
        .rd_data_i  (rd_data),
        .co_c25_o   (co_c25),
        .co_c64_o   (co_c64),
        .rd_addr_o  (rd_addr),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data)
    );

    assign wr_en = write;

endmodule

// File: tb/tb_rho_rotate.sv
// Directed bench for rho_rotate with behavioural input/output slice memories.
module tb_rho_rotate;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  rd_addr;
    logic [24:0] rd_data;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [24:0] wr_data;
    logic        busy;
    logic        ready;

    logic [24:0] in_mem  [64];
    logic [24:0] out_mem [64];

    int total = 0;
    int bad   = 0;
    int wr_cnt, rdy_cnt, rdy_n, tim_err;

    always #5 clk = ~clk;

    rho_rotate dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .ready   (ready)
    );

    assign rd_data = in_mem[rd_addr];

    always @(posedge clk) if (wr_en) out_mem[wr_addr] <= wr_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_mems();
        for (int k = 0; k < 64; k++) begin
            in_mem[k]  = '0;
            out_mem[k] = '0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"},   {26'd0, rd_addr}, 32'd0);
        chk({tag, "_wr"},   {5'd0, wr_en, wr_addr, wr_data}, 32'd0);
        chk({tag, "_bsy"},  {30'd0, busy, ready}, 32'd0);
    endtask

    // Pulse start for 3 cycles, then watch 1670 cycles after START exit.
    // rst_at>0 fires an async reset at that cycle; poke re-pulses start mid-COLLECT.
    task automatic run_pass(input int rst_at, input bit poke);
        wr_cnt = 0; rdy_cnt = 0; rdy_n = 0; tim_err = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_quiet", {25'd0, wr_en, rd_addr}, 32'd0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 1670; n++) begin
            @(negedge clk);
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                chk_all_zero("midrst");
                @(negedge clk) rst = 1'b0;
                return;
            end
            if (n == 1) chk("coll_busy", {31'd0, busy}, 32'd1);
            if (n == 3) chk("rd_addr_i2", {26'd0, rd_addr}, 32'd2);
            if (poke && n == 100) start = 1'b1;
            if (poke && n == 103) start = 1'b0;
            if (wr_en) begin
                if (n != 26 * (wr_cnt + 1) || wr_addr != wr_cnt[5:0]) tim_err++;
                wr_cnt++;
            end
            if (ready) begin
                rdy_cnt++;
                rdy_n = n;
            end
        end
        chk("wr_count", wr_cnt, 64);
        chk("wr_timing", tim_err, 0);
        chk("rdy_count", rdy_cnt, 1);
        chk("rdy_cycle", rdy_n, 1665);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int nz, ones;
        rst   = 1'b1;
        start = 1'b0;
        clear_mems();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Reset mid-pass, then a clean full pass.
        for (int k = 0; k < 64; k++) in_mem[k] = 25'h1FFFFFF;
        run_pass(500, 1'b0);
        chk("midrst_rdy", rdy_cnt, 0);
        chk("midrst_out18", {7'd0, out_mem[18]}, 32'h1FFFFFF);
        chk("midrst_out19", {7'd0, out_mem[19]}, 32'h0);
        @(negedge clk);
        chk_all_zero("postrst");
        run_pass(0, 1'b0);
        ones = 0;
        for (int k = 0; k < 64; k++) if (out_mem[k] == 25'h1FFFFFF) ones++;
        chk("all_ones", ones, 64);

        // Single bit, zero offset.
        clear_mems();
        in_mem[5] = 25'h0000001;
        run_pass(0, 1'b0);
        chk("bit0_out5", {7'd0, out_mem[5]}, 32'h1);
        nz = 0;
        for (int k = 0; k < 64; k++) if (k != 5 && out_mem[k] != '0) nz++;
        chk("bit0_others", nz, 0);

        // Wrap-around.
        clear_mems();
        in_mem[30] = 25'h0000040;
        in_mem[63] = 25'h0000002;
        run_pass(0, 1'b0);
        chk("wrap_out10", {7'd0, out_mem[10]}, 32'h40);
        chk("wrap_out0", {7'd0, out_mem[0]}, 32'h2);
        nz = 0;
        for (int k = 0; k < 64; k++) if (k != 10 && k != 0 && out_mem[k] != '0) nz++;
        chk("wrap_others", nz, 0);

        // in[0] all ones scatters lane i to slice r_i; extra start mid-COLLECT ignored.
        clear_mems();
        in_mem[0] = 25'h1FFFFFF;
        run_pass(0, 1'b1);
        chk("sc_out0",  {7'd0, out_mem[0]},  32'h0000001);
        chk("sc_out1",  {7'd0, out_mem[1]},  32'h0000002);
        chk("sc_out62", {7'd0, out_mem[62]}, 32'h0000004);
        chk("sc_out61", {7'd0, out_mem[61]}, 32'h0400000);
        chk("sc_out2",  {7'd0, out_mem[2]},  32'h0200000);
        chk("sc_out44", {7'd0, out_mem[44]}, 32'h0000040);
        chk("sc_out3",  {7'd0, out_mem[3]},  32'h0000400);
        chk("sc_out14", {7'd0, out_mem[14]}, 32'h1000000);
        chk("sc_out28", {7'd0, out_mem[28]}, 32'h0000008);
        nz = 0;
        for (int k = 0; k < 64; k++) if (out_mem[k] != '0) nz++;
        chk("sc_nonzero", nz, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
